io_read_port_arbiter: RTL and testbench

Shares one Datapath I/O read port between REQUESTER_COUNT external producers, each using a valid/ready stream interface. Producers are picked round-robin. The chosen word is captured in a holding register and presented to the Datapath as read data, with its empty/full flag (EF) asserted. When the Datapath pulses its read enable, the word is consumed and kept stable for the memory-read stages. The block sits between the system's producer logic and one lane of the Datapath `io_read_data_A`/`io_read_EF_A`/`io_rden_A` (or B) bus.

---
 rtl/io_arbiter_pkg.sv | 20 ++
 rtl/round_robin_arbiter.sv | 37 +++
 rtl/io_read_port_arbiter.sv | 111 +++++++++++
 tb/tb_io_read_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_arbiter_pkg.sv
// Shared types for the Datapath I/O read-port arbiter: holding-register state
// encoding and drain-counter sizing.
package io_arbiter_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;

   localparam int DEFAULT_REFILL_DELAY = 2;

   // Counter must hold REFILL_DELAY-1; keep at least one bit so REFILL_DELAY=1 still elaborates.
   function automatic int drain_cnt_width(input int refill_delay);
      return (refill_delay > 1) ? $clog2(refill_delay) : 1;
   endfunction

   localparam int DRAIN_CNT_WIDTH = drain_cnt_width(DEFAULT_REFILL_DELAY);

endpackage

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin pick: first asserted request at or above pointer,
// wrapping modulo REQUESTER_COUNT.
module round_robin_arbiter #(
   parameter int REQUESTER_COUNT       = 4,
   parameter int REQUESTER_COUNT_WIDTH = 2
) (
   input  logic [REQUESTER_COUNT-1:0]       request,
   input  logic [REQUESTER_COUNT_WIDTH-1:0] pointer,
   output logic [REQUESTER_COUNT-1:0]       grant,
   output logic [REQUESTER_COUNT_WIDTH-1:0] grant_idx,
   output logic                             any_grant
);

   logic [REQUESTER_COUNT_WIDTH:0]   slot;
   logic [REQUESTER_COUNT_WIDTH-1:0] idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      slot      = '0;
      idx       = '0;
      for (int k = 0; k < REQUESTER_COUNT; k++) begin
         // One extra bit so pointer+k cannot overflow before the modulo fold.
         slot = {1'b0, pointer} + (REQUESTER_COUNT_WIDTH + 1)'(k);
         if (slot >= (REQUESTER_COUNT_WIDTH + 1)'(REQUESTER_COUNT))
            slot = slot - (REQUESTER_COUNT_WIDTH + 1)'(REQUESTER_COUNT);
         idx = slot[REQUESTER_COUNT_WIDTH-1:0];
         if (!any_grant && request[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = idx;
            any_grant  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/io_read_port_arbiter.sv
// Round-robin funnel of valid/ready producers into one Datapath I/O read port;
// the word is held for REFILL_DELAY cycles after io_rden before refilling.
module io_read_port_arbiter
   import io_arbiter_pkg::*;
#(
   parameter int WORD_WIDTH            = 36,
   parameter int REQUESTER_COUNT       = 4,
   parameter int REQUESTER_COUNT_WIDTH = 2,
   parameter int REFILL_DELAY          = DEFAULT_REFILL_DELAY
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic [REQUESTER_COUNT-1:0]            req_valid,
   input  logic [REQUESTER_COUNT*WORD_WIDTH-1:0] req_data,
   output logic [REQUESTER_COUNT-1:0]            req_ready,
   output logic [WORD_WIDTH-1:0]                 io_read_data,
   output logic                                  io_read_EF,
   input  logic                                  io_rden,
   output logic [REQUESTER_COUNT_WIDTH-1:0]      source_id,
   output logic                                  underrun
);

   localparam int DRAIN_W = (REFILL_DELAY == DEFAULT_REFILL_DELAY) ? DRAIN_CNT_WIDTH
                                                                   : drain_cnt_width(REFILL_DELAY);

   arb_state_t                       state, state_next;
   logic [DRAIN_W-1:0]               drain_cnt, drain_cnt_next;
   logic [REQUESTER_COUNT_WIDTH-1:0] pointer, pointer_next;
   logic [REQUESTER_COUNT_WIDTH-1:0] grant_idx;
   logic [REQUESTER_COUNT-1:0]       grant;
   logic                             any_grant;
   logic                             transfer;
   logic [WORD_WIDTH-1:0]            req_word [REQUESTER_COUNT];

   for (genvar i = 0; i < REQUESTER_COUNT; i++) begin : g_unpack
      assign req_word[i] = req_data[i*WORD_WIDTH +: WORD_WIDTH];
   end

   round_robin_arbiter #(
      .REQUESTER_COUNT       (REQUESTER_COUNT),
      .REQUESTER_COUNT_WIDTH (REQUESTER_COUNT_WIDTH)
   ) u_rr (
      .request   (req_valid),
      .pointer   (pointer),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   always_comb begin
      state_next     = state;
      drain_cnt_next = drain_cnt;
      req_ready      = '0;
      transfer       = 1'b0;
      unique case (state)
         EMPTY: begin
            req_ready = grant;
            transfer  = any_grant;
            if (any_grant)
               state_next = FULL;
         end
         FULL: begin
            if (io_rden) begin
               drain_cnt_next = DRAIN_W'(REFILL_DELAY - 1);
               state_next     = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_cnt == '0)
               state_next = EMPTY;
            else
               drain_cnt_next = drain_cnt - 1'b1;
         end
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= EMPTY;
         drain_cnt <= '0;
      end else begin
         state     <= state_next;
         drain_cnt <= drain_cnt_next;
      end
   end

   assign pointer_next = (grant_idx == REQUESTER_COUNT_WIDTH'(REQUESTER_COUNT - 1))
                         ? '0 : grant_idx + 1'b1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         io_read_data <= '0;
         source_id    <= '0;
         pointer      <= '0;
         underrun     <= 1'b0;
      end else begin
         if (transfer) begin
            io_read_data <= req_word[grant_idx];
            source_id    <= grant_idx;
            pointer      <= pointer_next;
         end
         // A read outside FULL means the Datapath consumed a word that was never there.
         if (io_rden && state != FULL)
            underrun <= 1'b1;
      end
   end

   assign io_read_EF = (state == FULL);

endmodule

// File: tb/tb_io_read_port_arbiter.sv
// Directed bench for io_read_port_arbiter with a cycle-based reference model
// checked every negedge, plus literal expectations on key events.
module tb_io_read_port_arbiter;

   localparam int W  = 36;
   localparam int N  = 4;
   localparam int NW = 2;
   localparam int RD = 2;

   logic            clock;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N*W-1:0]  req_data;
   logic [N-1:0]    req_ready;
   logic [W-1:0]    io_read_data;
   logic            io_read_EF;
   logic            io_rden;
   logic [NW-1:0]   source_id;
   logic            underrun;

   logic [W-1:0]    word [N];

   int vectors     = 0;
   int miscompares = 0;

   io_read_port_arbiter #(
      .WORD_WIDTH(W), .REQUESTER_COUNT(N), .REQUESTER_COUNT_WIDTH(NW), .REFILL_DELAY(RD)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .io_read_data (io_read_data),
      .io_read_EF   (io_read_EF),
      .io_rden      (io_rden),
      .source_id    (source_id),
      .underrun     (underrun)
   );

   always_comb req_data = {word[3], word[2], word[1], word[0]};

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a word is either held or not; after a consume at edge R
   // no new word may be accepted before edge R+RD+1.
   int           ecount  = 0;
   bit           m_full  = 0;
   logic [W-1:0] m_data  = '0;
   int           m_src   = 0;
   int           m_ptr   = 0;
   int           m_free  = 0;
   bit           m_und   = 0;

   function automatic logic [N-1:0] grant_at(input int e);
      logic [N-1:0] g;
      g = '0;
      if (!m_full && e >= m_free) begin
         for (int k = 0; k < N; k++) begin
            if (g == '0 && req_valid[(m_ptr + k) % N])
               g[(m_ptr + k) % N] = 1'b1;
         end
      end
      return g;
   endfunction

   function automatic int onehot_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++)
         if (v[i]) return i;
      return -1;
   endfunction

   always @(posedge clock) begin
      logic [N-1:0] g;
      int           gi;
      ecount++;
      if (reset) begin
         m_full = 0; m_data = '0; m_src = 0; m_ptr = 0; m_free = 0; m_und = 0;
      end else begin
         g  = grant_at(ecount);
         gi = onehot_idx(g);
         if (io_rden) begin
            if (m_full) begin
               m_full = 0;
               m_free = ecount + RD + 1;
            end else begin
               m_und = 1;
            end
         end
         if (gi >= 0) begin
            m_full = 1;
            m_data = word[gi];
            m_src  = gi;
            m_ptr  = (gi + 1) % N;
         end
      end
   end

   always @(negedge clock) begin
      if (reset) begin
         check("rst_ef",   64'(io_read_EF),   64'(0));
         check("rst_data", 64'(io_read_data), 64'(0));
         check("rst_src",  64'(source_id),    64'(0));
         check("rst_und",  64'(underrun),     64'(0));
      end else begin
         check("ready", 64'(req_ready),    64'(grant_at(ecount + 1)));
         check("ef",    64'(io_read_EF),   64'(m_full));
         check("data",  64'(io_read_data), 64'(m_data));
         check("src",   64'(source_id),    64'(m_src));
         check("und",   64'(underrun),     64'(m_und));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected end before 100000");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = '0;
      io_rden   = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   int order[$];
   int exp_order[5] = '{0, 1, 2, 3, 0};

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      io_rden   = 1'b0;
      for (int i = 0; i < N; i++) word[i] = '0;
      do_reset();

      // Single producer on slot 2
      word[2]   = 36'h123;
      req_valid = 4'b0100;
      #1;
      check("single_ready", 64'(req_ready), 64'h4);
      tick();
      req_valid = '0;
      #1;
      check("single_ef",   64'(io_read_EF),   64'(1));
      check("single_data", 64'(io_read_data), 64'h123);
      check("single_src",  64'(source_id),    64'(2));

      // Round-robin fairness from a fresh pointer
      do_reset();
      for (int i = 0; i < N; i++) word[i] = 36'h100 + 36'(i);
      req_valid = 4'hF;
      for (int c = 0; c < 200 && order.size() < 5; c++) begin
         #1;
         if (req_ready != '0) order.push_back(onehot_idx(req_ready));
         io_rden = io_read_EF;
         tick();
      end
      io_rden = 1'b0;
      check("rr_count", 64'(order.size()), 64'(5));
      for (int i = 0; i < 5; i++)
         check("rr_order", 64'(i < order.size() ? order[i] : -1), 64'(exp_order[i]));

      // Hold after consume: word 0x100 is FULL, pointer is 1
      #1;
      io_rden = 1'b1;
      tick();
      io_rden = 1'b0;
      #1;
      check("hold_ef_r1",   64'(io_read_EF),   64'(0));
      check("hold_data_r1", 64'(io_read_data), 64'h100);
      tick();
      #1;
      check("hold_ready_r2", 64'(req_ready),    64'(0));
      check("hold_data_r2",  64'(io_read_data), 64'h100);
      tick();
      #1;
      check("hold_ready_r3", 64'(req_ready),    64'h2);
      check("hold_data_r3",  64'(io_read_data), 64'h100);
      tick();
      #1;
      check("refill_ef",   64'(io_read_EF),   64'(1));
      check("refill_data", 64'(io_read_data), 64'h101);

      // Stall with all producers waiting
      repeat (50) tick();
      #1;
      check("stall_ready", 64'(req_ready),    64'(0));
      check("stall_data",  64'(io_read_data), 64'h101);
      io_rden = 1'b1;
      tick();
      io_rden = 1'b0;
      tick();
      tick();
      #1;
      check("stall_ptr", 64'(req_ready), 64'h4);
      req_valid = '0;
      tick();

      // Underrun in EMPTY, then in DRAIN
      do_reset();
      io_rden = 1'b1;
      tick();
      io_rden = 1'b0;
      #1;
      check("und_empty",    64'(underrun),   64'(1));
      check("und_empty_ef", 64'(io_read_EF), 64'(0));
      word[0]   = 36'h55;
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      io_rden   = 1'b1;
      tick();
      tick();
      io_rden = 1'b0;
      #1;
      check("und_drain",      64'(underrun),     64'(1));
      check("und_drain_data", 64'(io_read_data), 64'h55);
      repeat (3) tick();

      // Reset while FULL
      word[1]   = 36'hABC;
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      #1;
      check("pre_rst_data", 64'(io_read_data), 64'hABC);
      reset = 1'b1;
      #1;
      check("mid_rst_ef",    64'(io_read_EF),   64'(0));
      check("mid_rst_data",  64'(io_read_data), 64'(0));
      check("mid_rst_src",   64'(source_id),    64'(0));
      check("mid_rst_und",   64'(underrun),     64'(0));
      check("mid_rst_ready", 64'(req_ready),    64'(0));
      tick();
      req_valid = 4'hF;
      reset     = 1'b0;
      #1;
      check("post_rst_ready", 64'(req_ready), 64'h1);
      tick();
      req_valid = '0;
      #1;
      check("post_rst_src", 64'(source_id), 64'(0));
      io_rden = 1'b1;
      tick();
      io_rden = 1'b0;
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
